// File: rtl/char_bbox_pkg.sv
// Shared types and defaults for the per-strip character bounding-box extractor.
package char_bbox_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2,
        LATCH = 2'd3
    } state_t;

    // Accumulator clear value: min fills with ones, max and count fill with zeros.
    localparam bit CLR_MIN_FILL = 1'b1;
    localparam bit CLR_MAX_FILL = 1'b0;

    localparam int DEF_H_ACTIVE    = 1280;
    localparam int DEF_V_ACTIVE    = 720;
    localparam int DEF_XW          = 11;
    localparam int DEF_YW          = 10;
    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_STRIP_SHIFT = 8;
    localparam int DEF_CW          = 16;
    localparam int DEF_MIN_PIX     = 16;

    // Registered channel index width; enough for up to 8 strips.
    localparam int CH_IDX_W = 3;

endpackage

// File: rtl/char_bbox_acc.sv
// One strip's min/max/count accumulator.
module char_bbox_acc
    import char_bbox_pkg::*;
#(
    parameter int XW = DEF_XW,
    parameter int YW = DEF_YW,
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          upd,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    output logic [XW-1:0] x_min,
    output logic [XW-1:0] x_max,
    output logic [YW-1:0] y_min,
    output logic [YW-1:0] y_max,
    output logic [CW-1:0] cnt
);

    // Clear to the empty box, otherwise widen the box and bump the saturating count.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            x_min <= {XW{CLR_MIN_FILL}};
            y_min <= {YW{CLR_MIN_FILL}};
            x_max <= {XW{CLR_MAX_FILL}};
            y_max <= {YW{CLR_MAX_FILL}};
            cnt   <= '0;
        end else if (upd) begin
            if (x < x_min) x_min <= x;
            if (x > x_max) x_max <= x;
            if (y < y_min) y_min <= y;
            if (y > y_max) y_max <= y;
            if (cnt != '1) cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/char_bbox_multi.sv
// Per-frame multi-strip character bounding-box extractor, latched at each VSync rise.
module char_bbox_multi
    import char_bbox_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int XW          = DEF_XW,
    parameter int YW          = DEF_YW,
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int STRIP_SHIFT = DEF_STRIP_SHIFT,
    parameter int CW          = DEF_CW,
    parameter int MIN_PIX     = DEF_MIN_PIX
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Y,
    input  logic                 HSync,
    input  logic                 VSync,
    input  logic                 VDE,
    input  logic [XW-1:0]        x_num,
    input  logic [YW-1:0]        y_num,
    output logic [NUM_CH*XW-1:0] x_min,
    output logic [NUM_CH*XW-1:0] x_max,
    output logic [NUM_CH*YW-1:0] y_min,
    output logic [NUM_CH*YW-1:0] y_max,
    output logic [NUM_CH*CW-1:0] pix_cnt,
    output logic [NUM_CH-1:0]    box_valid,
    output logic                 frame_done
);

    localparam logic [31:0] H_LIM   = H_ACTIVE;
    localparam logic [31:0] V_LIM   = V_ACTIVE;
    localparam logic [31:0] CH_LIM  = NUM_CH;
    localparam logic [31:0] MIN_LIM = MIN_PIX;

    state_t state, next_state;

    logic                pix_v;
    logic [XW-1:0]       x_r;
    logic [YW-1:0]       y_r;
    logic [CH_IDX_W-1:0] ch_r;
    logic                vs_r;

    logic [XW-1:0] ch_full;
    logic          pix_ok;
    logic          vs_rise;
    logic          acc_clr;
    logic          acc_en;

    assign ch_full = x_num >> STRIP_SHIFT;
    assign pix_ok  = !VSync && HSync && VDE && Y
                   && (32'(x_num) < H_LIM)
                   && (32'(y_num) < V_LIM)
                   && (32'(ch_full) < CH_LIM);
    assign vs_rise = VSync && !vs_r;

    // Stage 0: qualify and register the incoming pixel and VSync history.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_v <= 1'b0;
            x_r   <= '0;
            y_r   <= '0;
            ch_r  <= '0;
            vs_r  <= 1'b0;
        end else begin
            pix_v <= pix_ok;
            x_r   <= x_num;
            y_r   <= y_num;
            ch_r  <= ch_full[CH_IDX_W-1:0];
            vs_r  <= VSync;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // FSM next state; IDLE holds the accumulators clear so the partial first frame is discarded.
    always_comb begin
        next_state = state;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;
        case (state)
            IDLE: begin
                acc_clr = 1'b1;
                if (vs_rise) next_state = ACCUM;
            end
            ACCUM: begin
                acc_en = 1'b1;
                if (vs_rise) next_state = FLUSH;
            end
            FLUSH: begin
                acc_en     = 1'b1;
                next_state = LATCH;
            end
            LATCH: begin
                acc_clr    = 1'b1;
                next_state = ACCUM;
            end
            default: next_state = IDLE;
        endcase
    end

    // One-cycle result strobe, raised by the cycle spent in LATCH.
    always_ff @(posedge clk) begin
        if (rst) frame_done <= 1'b0;
        else     frame_done <= (state == LATCH);
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [XW-1:0] ax_min, ax_max, lx_min, lx_max;
        logic [YW-1:0] ay_min, ay_max, ly_min, ly_max;
        logic [CW-1:0] a_cnt, l_cnt;
        logic          l_valid;

        char_bbox_acc #(
            .XW(XW),
            .YW(YW),
            .CW(CW)
        ) u_acc (
            .clk  (clk),
            .rst  (rst),
            .clr  (acc_clr),
            .upd  (acc_en && pix_v && (ch_r == CH_IDX_W'(g))),
            .x    (x_r),
            .y    (y_r),
            .x_min(ax_min),
            .x_max(ax_max),
            .y_min(ay_min),
            .y_max(ay_max),
            .cnt  (a_cnt)
        );

        // Output latch for this strip; an empty strip reports an all-zero box.
        always_ff @(posedge clk) begin
            if (rst) begin
                lx_min  <= '0;
                lx_max  <= '0;
                ly_min  <= '0;
                ly_max  <= '0;
                l_cnt   <= '0;
                l_valid <= 1'b0;
            end else if (state == LATCH) begin
                if (a_cnt == '0) begin
                    lx_min <= '0;
                    lx_max <= '0;
                    ly_min <= '0;
                    ly_max <= '0;
                end else begin
                    lx_min <= ax_min;
                    lx_max <= ax_max;
                    ly_min <= ay_min;
                    ly_max <= ay_max;
                end
                l_cnt   <= a_cnt;
                l_valid <= (32'(a_cnt) >= MIN_LIM);
            end
        end

        assign x_min[g*XW +: XW]   = lx_min;
        assign x_max[g*XW +: XW]   = lx_max;
        assign y_min[g*YW +: YW]   = ly_min;
        assign y_max[g*YW +: YW]   = ly_max;
        assign pix_cnt[g*CW +: CW] = l_cnt;
        assign box_valid[g]        = l_valid;
    end

endmodule

// File: tb/tb_char_bbox_multi.sv
// Scoreboard bench: a frame-level reference model queues expected box sets on each VSync rise,
// and a monitor checks them when frame_done pulses, plus output hold in between.
module tb_char_bbox_multi;

    logic        clk = 1'b0;
    logic        rst, Y, HSync, VSync, VDE;
    logic [10:0] x_num;
    logic [9:0]  y_num;

    logic [43:0] x_min, x_max, s_x_min, s_x_max;
    logic [39:0] y_min, y_max, s_y_min, s_y_max;
    logic [63:0] pix_cnt;
    logic [15:0] s_pix_cnt;
    logic [3:0]  box_valid, s_box_valid;
    logic        frame_done, s_frame_done;

    always #5 clk = ~clk;

    char_bbox_multi u_main (
        .clk(clk), .rst(rst), .Y(Y), .HSync(HSync), .VSync(VSync), .VDE(VDE),
        .x_num(x_num), .y_num(y_num),
        .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
        .pix_cnt(pix_cnt), .box_valid(box_valid), .frame_done(frame_done)
    );

    char_bbox_multi #(.CW(4), .MIN_PIX(1)) u_sat (
        .clk(clk), .rst(rst), .Y(Y), .HSync(HSync), .VSync(VSync), .VDE(VDE),
        .x_num(x_num), .y_num(y_num),
        .x_min(s_x_min), .x_max(s_x_max), .y_min(s_y_min), .y_max(s_y_max),
        .pix_cnt(s_pix_cnt), .box_valid(s_box_valid), .frame_done(s_frame_done)
    );

    typedef struct packed {
        logic [43:0] xmin;
        logic [43:0] xmax;
        logic [39:0] ymin;
        logic [39:0] ymax;
        logic [63:0] cnt;
        logic [3:0]  valid;
        logic [15:0] cnt_s;
        logic [3:0]  valid_s;
        logic [31:0] done_cyc;
    } exp_t;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
    } px_t;

    exp_t exp_q[$];
    exp_t cur;
    px_t  frame_px[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit armed  = 0;
    bit prev_vs = 0;
    bit mon_en = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: bounding box of every accepted pixel of the frame, grouped by 256-wide strip.
    function automatic exp_t build_exp(int done_cyc);
        exp_t e;
        int mnx[4], mxx[4], mny[4], mxy[4], n[4];
        e = '0;
        for (int k = 0; k < 4; k++) begin
            mnx[k] = 1 << 30; mny[k] = 1 << 30; mxx[k] = -1; mxy[k] = -1; n[k] = 0;
        end
        foreach (frame_px[i]) begin
            int k, x, y;
            x = int'(frame_px[i].x);
            y = int'(frame_px[i].y);
            k = x / 256;
            n[k]++;
            if (x < mnx[k]) mnx[k] = x;
            if (x > mxx[k]) mxx[k] = x;
            if (y < mny[k]) mny[k] = y;
            if (y > mxy[k]) mxy[k] = y;
        end
        for (int k = 0; k < 4; k++) begin
            if (n[k] > 0) begin
                e.xmin[k*11 +: 11] = 11'(mnx[k]);
                e.xmax[k*11 +: 11] = 11'(mxx[k]);
                e.ymin[k*10 +: 10] = 10'(mny[k]);
                e.ymax[k*10 +: 10] = 10'(mxy[k]);
            end
            e.cnt[k*16 +: 16] = 16'((n[k] > 65535) ? 65535 : n[k]);
            e.valid[k]        = (n[k] >= 16);
            e.cnt_s[k*4 +: 4] = 4'((n[k] > 15) ? 15 : n[k]);
            e.valid_s[k]      = (n[k] >= 1);
        end
        e.done_cyc = 32'(done_cyc);
        return e;
    endfunction

    // Frame model: a VSync rise closes the frame (the first one after reset only arms);
    // foreground inside the active area with VSync low belongs to the open frame.
    task automatic sample_model();
        if (VSync && !prev_vs) begin
            if (armed) exp_q.push_back(build_exp(cyc + 3));
            armed = 1;
            frame_px.delete();
        end else if (!VSync && HSync && VDE && Y && x_num < 1280 && y_num < 720 && (x_num / 256) < 4) begin
            frame_px.push_back('{x: x_num, y: y_num});
        end
        prev_vs = VSync;
    endtask

    task automatic drive(bit yv, bit hs, bit de, bit vs, int x, int y);
        Y = yv; HSync = hs; VDE = de; VSync = vs;
        x_num = 11'(x); y_num = 10'(y);
        sample_model();
        @(posedge clk); #1;
    endtask

    task automatic pixel(int x, int y);
        drive(1, 1, 1, 0, x, y);
    endtask

    task automatic blank(int n);
        repeat (n) drive(0, 1, 1, 0, $urandom % 1280, $urandom % 720);
    endtask

    task automatic vs_pulse(int n);
        repeat (n) drive(1'($urandom % 2), 1, 1, 1, $urandom % 1280, $urandom % 720);
    endtask

    task automatic do_reset();
        rst = 1; VSync = 0; Y = 0; HSync = 0; VDE = 0;
        @(posedge clk); #1;
        rst = 0;
        armed = 0; prev_vs = 0;
        frame_px.delete();
        cur = '0;
        mon_en = 1;
        check("rst_frame_done", 256'(frame_done), 256'(0));
        check("rst_outputs", {x_min, x_max, y_min, y_max, pix_cnt, box_valid}, 256'(0));
        check("rst_sat_outputs", {s_x_min, s_x_max, s_y_min, s_y_max, s_pix_cnt, s_box_valid, s_frame_done}, 256'(0));
    endtask

    // Raise VSync while accumulating, then reset while the FSM sits in FLUSH.
    task automatic vs_then_reset();
        Y = 1; HSync = 1; VDE = 1; VSync = 1;
        @(posedge clk); #1;
        do_reset();
    endtask

    // Monitor: pop an expectation on each frame_done, otherwise the outputs must hold.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (frame_done || s_frame_done) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_frame_done: got 1 expected 0 at cycle %0d", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("latency", 256'(cyc), 256'(e.done_cyc));
                        check("frame_done_both", {frame_done, s_frame_done}, 256'(3));
                        check("x_min", 256'(x_min), 256'(e.xmin));
                        check("x_max", 256'(x_max), 256'(e.xmax));
                        check("y_min", 256'(y_min), 256'(e.ymin));
                        check("y_max", 256'(y_max), 256'(e.ymax));
                        check("pix_cnt", 256'(pix_cnt), 256'(e.cnt));
                        check("box_valid", 256'(box_valid), 256'(e.valid));
                        check("sat_box", {s_x_min, s_x_max, s_y_min, s_y_max}, {e.xmin, e.xmax, e.ymin, e.ymax});
                        check("sat_pix_cnt", 256'(s_pix_cnt), 256'(e.cnt_s));
                        check("sat_box_valid", 256'(s_box_valid), 256'(e.valid_s));
                        cur = e;
                    end
                end else begin
                    check("hold_main", {x_min, x_max, y_min, y_max, pix_cnt, box_valid},
                          {cur.xmin, cur.xmax, cur.ymin, cur.ymax, cur.cnt, cur.valid});
                    check("hold_sat", {s_x_min, s_x_max, s_y_min, s_y_max, s_pix_cnt, s_box_valid},
                          {cur.xmin, cur.xmax, cur.ymin, cur.ymax, cur.cnt_s, cur.valid_s});
                end
            end
        end
    end

    initial begin
        int wait_cnt;
        rst = 1; Y = 0; HSync = 0; VSync = 0; VDE = 0; x_num = '0; y_num = '0;
        cur = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Dummy VSync arms the extractor; the pixel before it must be discarded.
        pixel(20, 20);
        blank(3);
        vs_pulse(3);

        // Single foreground pixel in strip 1.
        blank(5);
        pixel(300, 100);
        blank(5);
        vs_pulse(3);

        // Two rectangles in strips 0 and 2.
        for (int y = 20; y <= 40; y++)
            for (int x = 10; x <= 50; x++) pixel(x, y);
        for (int y = 200; y <= 260; y++)
            for (int x = 600; x <= 700; x++) pixel(x, y);
        vs_pulse(3);

        // Box frame followed by a blank frame.
        for (int i = 0; i < 20; i++) pixel(5 + i, 7 + i);
        vs_pulse(3);
        blank(20);
        vs_pulse(3);

        // Strip boundaries, last active pixel, out-of-range and gated pixels, pixel right before the rise.
        pixel(255, 10);
        pixel(256, 11);
        pixel(1279, 719);
        pixel(1280, 5);
        pixel(1000, 720);
        drive(1, 0, 1, 0, 512, 3);
        drive(1, 1, 0, 0, 520, 4);
        pixel(700, 50);
        vs_pulse(2);

        // Reset while in FLUSH abandons the frame; the next rise only re-arms.
        for (int i = 0; i < 10; i++) pixel(100 + i, 30);
        vs_then_reset();
        pixel(100, 100);
        blank(4);
        vs_pulse(3);
        for (int i = 0; i < 17; i++) pixel(800 + i * 3, 600 - i);
        pixel(40, 40);
        vs_pulse(4);

        // Randomised frames.
        for (int f = 0; f < 8; f++) begin
            int n;
            n = 150 + int'($urandom % 250);
            for (int i = 0; i < n; i++)
                drive(($urandom % 10) < 7, ($urandom % 10) != 0, ($urandom % 10) != 0, 0,
                      $urandom % 1400, $urandom % 760);
            vs_pulse(2 + int'($urandom % 4));
        end

        blank(6);
        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 20) begin
            blank(1);
            wait_cnt++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending results expected 0", exp_q.size());
        end
        blank(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
